// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW colour engine: the mode codes, the state
// encoding and the small colour-arithmetic helpers.
package rgbw_pkg;

    // Default mode codes accepted on start.
    localparam logic [7:0] MODE_BYPASS_DEF  = 8'h21;
    localparam logic [7:0] MODE_WHEEL_DEF   = 8'hA4;
    localparam logic [7:0] MODE_EXTRACT_DEF = 8'hB5;

    // Widest colour field the helpers support; callers zero-extend into it.
    localparam int MAX_DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HUE   = 3'd1,
        ST_TINT  = 3'd2,
        ST_MUL_W = 3'd3,
        ST_MUL_R = 3'd4,
        ST_MUL_G = 3'd5,
        ST_MUL_B = 3'd6,
        ST_OUT   = 3'd7
    } state_t;

    // a + b clamped to max_v, so adding tint never wraps a channel.
    function automatic logic [MAX_DW-1:0] sat_add(input logic [MAX_DW-1:0] a,
                                                   input logic [MAX_DW-1:0] b,
                                                   input logic [MAX_DW-1:0] max_v);
        logic [MAX_DW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[MAX_DW-1:0];
    endfunction

    // Smallest of three values: the white component common to R, G and B.
    function automatic logic [MAX_DW-1:0] min3(input logic [MAX_DW-1:0] a,
                                               input logic [MAX_DW-1:0] b,
                                               input logic [MAX_DW-1:0] c);
        logic [MAX_DW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

endpackage

// File: rtl/rgbw_hue_engine_if.sv
// Bus to the shared external sequential multiplier (ld/ok handshake).
interface rgbw_hue_engine_if #(
    parameter int DW = 8
);
    logic [DW-1:0]   mult_a;
    logic [DW-1:0]   mult_b;
    logic            mult_ld;
    logic            mult_ok;
    logic [2*DW-1:0] mult_res;

    // The engine issues operands and the load request.
    modport master (
        output mult_a, mult_b, mult_ld,
        input  mult_ok, mult_res
    );

    // The multiplier answers with a product and a valid flag.
    modport slave (
        input  mult_a, mult_b, mult_ld,
        output mult_ok, mult_res
    );
endinterface

// File: rtl/hue_sector_map.sv
// Hue index to fully saturated R/G/B: six sectors of the colour wheel, with
// the fractional position inside a sector giving the rising/falling ramp.
module hue_sector_map #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] hue_i,
    output logic [DW-1:0] red_o,
    output logic [DW-1:0] green_o,
    output logic [DW-1:0] blue_o
);
    logic [DW+2:0] p;
    logic [2:0]    sec;
    logic [DW-1:0] f;
    logic [DW-1:0] d;
    logic [DW-1:0] m;

    // hue*6 spreads the index over six sectors; the top bits select the sector.
    assign p   = (DW+3)'(hue_i) * (DW+3)'(6);
    assign sec = p[DW+2:DW];
    assign f   = p[DW-1:0];
    assign m   = '1;
    assign d   = m - f;

    // Per-sector channel selection: one channel full, one ramping, one off.
    always_comb begin
        red_o   = '0;
        green_o = '0;
        blue_o  = '0;
        case (sec)
            3'd0: begin red_o = m; green_o = f; end
            3'd1: begin red_o = d; green_o = m; end
            3'd2: begin green_o = m; blue_o = f; end
            3'd3: begin green_o = d; blue_o = m; end
            3'd4: begin red_o = f; blue_o = m; end
            3'd5: begin red_o = m; blue_o = d; end
            default: ;
        endcase
    end
endmodule

// File: rtl/rgbw_hue_engine.sv
// RGBW colour engine: hue wheel + tint, or RGB white extraction, followed by
// intensity scaling of all four channels on the shared external multiplier.
module rgbw_hue_engine
    import rgbw_pkg::*;
#(
    parameter int         DW           = 8,
    parameter logic [7:0] MODE_BYPASS  = MODE_BYPASS_DEF,
    parameter logic [7:0] MODE_WHEEL   = MODE_WHEEL_DEF,
    parameter logic [7:0] MODE_EXTRACT = MODE_EXTRACT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    mode,
    input  logic [DW-1:0] hue,
    input  logic [DW-1:0] lint,
    input  logic [DW-1:0] white_in,
    input  logic [DW-1:0] red_in,
    input  logic [DW-1:0] green_in,
    input  logic [DW-1:0] blue_in,
    rgbw_hue_engine_if.master mul,
    output logic          busy,
    output logic          out_valid,
    output logic [DW-1:0] red_out,
    output logic [DW-1:0] green_out,
    output logic [DW-1:0] blue_out,
    output logic [DW-1:0] white_out
);
    localparam logic [DW-1:0] FULL = '1;

    state_t        state_q, state_d;
    logic [7:0]    mode_q, mode_d;
    logic [DW-1:0] hue_q, hue_d;
    logic [DW-1:0] lint_q, lint_d;
    logic [DW-1:0] win_q, win_d;
    logic [DW-1:0] rin_q, rin_d;
    logic [DW-1:0] gin_q, gin_d;
    logic [DW-1:0] bin_q, bin_d;
    // Working channel values, overwritten in place by their scaled versions.
    logic [DW-1:0] w_q, w_d;
    logic [DW-1:0] r_q, r_d;
    logic [DW-1:0] g_q, g_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] red_out_q, red_out_d;
    logic [DW-1:0] green_out_q, green_out_d;
    logic [DW-1:0] blue_out_q, blue_out_d;
    logic [DW-1:0] white_out_q, white_out_d;
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;
    logic          mult_ld_q, mult_ld_d;

    logic [DW-1:0] map_r, map_g, map_b;
    logic [DW-1:0] ext_w;
    logic [DW-1:0] cur_x;
    logic [DW-1:0] scaled;
    logic          in_mul;

    hue_sector_map #(.DW(DW)) u_hue_map (
        .hue_i   (hue_q),
        .red_o   (map_r),
        .green_o (map_g),
        .blue_o  (map_b)
    );

    assign ext_w = DW'(min3(MAX_DW'(rin_q), MAX_DW'(gin_q), MAX_DW'(bin_q)));

    assign in_mul = (state_q == ST_MUL_W) || (state_q == ST_MUL_R) ||
                    (state_q == ST_MUL_G) || (state_q == ST_MUL_B);

    // Operand currently being scaled, chosen by the multiply step.
    always_comb begin
        cur_x = '0;
        case (state_q)
            ST_MUL_W: cur_x = w_q;
            ST_MUL_R: cur_x = r_q;
            ST_MUL_G: cur_x = g_q;
            ST_MUL_B: cur_x = b_q;
            default:  ;
        endcase
    end

    // x*(lint+1)>>DW computed as (x*lint + x)>>DW, so lint=all-ones is exact.
    assign scaled = DW'((mul.mult_res + (2*DW)'(cur_x)) >> DW);

    assign mul.mult_a  = in_mul ? lint_q : '0;
    assign mul.mult_b  = cur_x;
    assign mul.mult_ld = mult_ld_q;

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign red_out   = red_out_q;
    assign green_out = green_out_q;
    assign blue_out  = blue_out_q;
    assign white_out = white_out_q;

    // Next-state, datapath and multiplier-handshake decisions.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        hue_d       = hue_q;
        lint_d      = lint_q;
        win_d       = win_q;
        rin_d       = rin_q;
        gin_d       = gin_q;
        bin_d       = bin_q;
        w_d         = w_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        red_out_d   = red_out_q;
        green_out_d = green_out_q;
        blue_out_d  = blue_out_q;
        white_out_d = white_out_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        mult_ld_d   = mult_ld_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    hue_d  = hue;
                    lint_d = lint;
                    win_d  = white_in;
                    rin_d  = red_in;
                    gin_d  = green_in;
                    bin_d  = blue_in;
                    if (mode == MODE_BYPASS) begin
                        red_out_d   = red_in;
                        green_out_d = green_in;
                        blue_out_d  = blue_in;
                        white_out_d = white_in;
                        out_valid_d = 1'b1;
                    end else if (mode == MODE_WHEEL) begin
                        busy_d  = 1'b1;
                        state_d = ST_HUE;
                    end else if (mode == MODE_EXTRACT) begin
                        busy_d  = 1'b1;
                        state_d = ST_TINT;
                    end
                end
            end
            ST_HUE: begin
                r_d     = map_r;
                g_d     = map_g;
                b_d     = map_b;
                state_d = ST_TINT;
            end
            ST_TINT: begin
                if (mode_q == MODE_WHEEL) begin
                    r_d = DW'(sat_add(MAX_DW'(r_q), MAX_DW'(win_q), MAX_DW'(FULL)));
                    g_d = DW'(sat_add(MAX_DW'(g_q), MAX_DW'(win_q), MAX_DW'(FULL)));
                    b_d = DW'(sat_add(MAX_DW'(b_q), MAX_DW'(win_q), MAX_DW'(FULL)));
                    w_d = win_q;
                end else begin
                    w_d = ext_w;
                    r_d = rin_q - ext_w;
                    g_d = gin_q - ext_w;
                    b_d = bin_q - ext_w;
                end
                state_d = ST_MUL_W;
            end
            ST_MUL_W, ST_MUL_R, ST_MUL_G, ST_MUL_B: begin
                if (mult_ld_q && mul.mult_ok) begin
                    mult_ld_d = 1'b0;
                    case (state_q)
                        ST_MUL_W: begin w_d = scaled; state_d = ST_MUL_R; end
                        ST_MUL_R: begin r_d = scaled; state_d = ST_MUL_G; end
                        ST_MUL_G: begin g_d = scaled; state_d = ST_MUL_B; end
                        default:  begin b_d = scaled; state_d = ST_OUT;   end
                    endcase
                end else if (!mul.mult_ok && !mult_ld_q) begin
                    // Wait for a stale ok from the previous product to drop.
                    mult_ld_d = 1'b1;
                end
            end
            ST_OUT: begin
                red_out_d   = r_q;
                green_out_d = g_q;
                blue_out_d  = b_q;
                white_out_d = w_q;
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, even mid-multiply.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            hue_q       <= '0;
            lint_q      <= '0;
            win_q       <= '0;
            rin_q       <= '0;
            gin_q       <= '0;
            bin_q       <= '0;
            w_q         <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            red_out_q   <= '0;
            green_out_q <= '0;
            blue_out_q  <= '0;
            white_out_q <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            mult_ld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            hue_q       <= hue_d;
            lint_q      <= lint_d;
            win_q       <= win_d;
            rin_q       <= rin_d;
            gin_q       <= gin_d;
            bin_q       <= bin_d;
            w_q         <= w_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            red_out_q   <= red_out_d;
            green_out_q <= green_out_d;
            blue_out_q  <= blue_out_d;
            white_out_q <= white_out_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            mult_ld_q   <= mult_ld_d;
        end
    end
endmodule

// File: tb/tb_rgbw_hue_engine.sv
// Scoreboard bench for rgbw_hue_engine with a behavioural multiplier model.
module tb_rgbw_hue_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] mode;
    logic [7:0] hue, lint, white_in, red_in, green_in, blue_in;
    logic       busy, out_valid;
    logic [7:0] red_out, green_out, blue_out, white_out;

    rgbw_hue_engine_if #(.DW(8)) mif ();

    rgbw_hue_engine #(.DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .hue       (hue),
        .lint      (lint),
        .white_in  (white_in),
        .red_in    (red_in),
        .green_in  (green_in),
        .blue_in   (blue_in),
        .mul       (mif.master),
        .busy      (busy),
        .out_valid (out_valid),
        .red_out   (red_out),
        .green_out (green_out),
        .blue_out  (blue_out),
        .white_out (white_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] w;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int pushed = 0;
    int outputs_seen = 0;
    int ld_rises = 0;
    int lat = 0;
    int mcnt = 0;
    logic ld_prev = 1'b0;
    logic ov_prev = 1'b0;

    function automatic exp_t mk(input int r, input int g, input int b, input int w);
        exp_t e;
        e.r = 8'(r); e.g = 8'(g); e.b = 8'(b); e.w = 8'(w);
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Multiplier with programmable latency; ok holds until ld is dropped.
    always @(posedge clk) begin
        if (!reset) begin
            mif.mult_ok  <= 1'b0;
            mif.mult_res <= '0;
            mcnt         <= 0;
        end else if (mif.mult_ok) begin
            if (!mif.mult_ld) mif.mult_ok <= 1'b0;
        end else if (mif.mult_ld) begin
            if (mcnt >= lat) begin
                mif.mult_ok  <= 1'b1;
                mif.mult_res <= 16'(mif.mult_a) * 16'(mif.mult_b);
                mcnt         <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every out_valid and compares.
    always @(negedge clk) begin
        if (mif.mult_ld && !ld_prev) ld_rises++;
        ld_prev = mif.mult_ld;
        if (out_valid) begin
            chk("ov_pulse_width", int'(ov_prev), 0);
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("red_out", int'(red_out), int'(e.r));
                chk("green_out", int'(green_out), int'(e.g));
                chk("blue_out", int'(blue_out), int'(e.b));
                chk("white_out", int'(white_out), int'(e.w));
                $display("txn %0d: R/G/B/W=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                         outputs_seen, red_out, green_out, blue_out, white_out,
                         e.r, e.g, e.b, e.w);
            end
            outputs_seen++;
        end
        ov_prev = out_valid;
    end

    // Pulse start for one cycle, then scramble inputs to prove they were latched.
    task automatic issue(input logic [7:0] md, input logic [7:0] hu, input logic [7:0] li,
                         input logic [7:0] wi, input logic [7:0] ri, input logic [7:0] gi,
                         input logic [7:0] bi, input bit do_push, input exp_t e);
        @(negedge clk);
        mode = md; hue = hu; lint = li;
        white_in = wi; red_in = ri; green_in = gi; blue_in = bi;
        start = 1'b1;
        if (do_push) begin
            sb.push_back(e);
            pushed++;
        end
        @(negedge clk);
        start = 1'b0;
        hue = ~hu; lint = ~li; white_in = ~wi; red_in = ~ri; green_in = ~gi; blue_in = ~bi;
    endtask

    task automatic wait_out(input int target, input string nm);
        int n;
        n = 0;
        while (outputs_seen < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, int'(outputs_seen >= target), 1);
    endtask

    task automatic run(input logic [7:0] md, input logic [7:0] hu, input logic [7:0] li,
                       input logic [7:0] wi, input logic [7:0] ri, input logic [7:0] gi,
                       input logic [7:0] bi, input exp_t e, input string nm);
        int tgt;
        tgt = outputs_seen + 1;
        issue(md, hu, li, wi, ri, gi, bi, 1'b1, e);
        wait_out(tgt, nm);
    endtask

    initial begin
        int base;
        int n;
        reset = 1'b0; start = 1'b0; mode = '0; hue = '0; lint = '0;
        white_in = '0; red_in = '0; green_in = '0; blue_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mult_ld", int'(mif.mult_ld), 0);
        chk("rst_red_out", int'(red_out), 0);
        chk("rst_white_out", int'(white_out), 0);
        reset = 1'b1;
        @(negedge clk);

        // Bypass: copy straight through, no multiplier traffic.
        base = ld_rises;
        run(8'h21, 8'd0, 8'd0, 8'd40, 8'd10, 8'd20, 8'd30, mk(10, 20, 30, 40), "bypass");
        chk("bypass_no_ld", ld_rises - base, 0);

        // Hue wheel cases.
        run(8'hA4, 8'd0,   8'd255, 8'd0,   8'd0, 8'd0, 8'd0, mk(255, 0, 0, 0),     "wheel_h0");
        run(8'hA4, 8'd43,  8'd255, 8'd0,   8'd0, 8'd0, 8'd0, mk(253, 255, 0, 0),   "wheel_h43");
        run(8'hA4, 8'd128, 8'd128, 8'd0,   8'd0, 8'd0, 8'd0, mk(0, 128, 128, 0),   "wheel_h128");
        run(8'hA4, 8'd0,   8'd255, 8'd100, 8'd0, 8'd0, 8'd0, mk(255, 100, 100, 100), "tint");
        run(8'hA4, 8'd255, 8'd255, 8'd0,   8'd0, 8'd0, 8'd0, mk(255, 0, 5, 0),     "wheel_wrap");
        run(8'hA4, 8'd0,   8'd0,   8'd50,  8'd0, 8'd0, 8'd0, mk(0, 0, 0, 0),       "lint_zero");

        // White extraction.
        run(8'hB5, 8'd0, 8'd255, 8'd0, 8'd200, 8'd150, 8'd50, mk(150, 100, 0, 50), "extract");
        repeat (5) @(negedge clk);
        chk("hold_red", int'(red_out), 150);
        chk("hold_white", int'(white_out), 50);
        run(8'hB5, 8'd0, 8'd128, 8'd0, 8'd200, 8'd150, 8'd50, mk(75, 50, 0, 25), "extract_half");

        // Slow multiplier: same result.
        lat = 5;
        run(8'hA4, 8'd128, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0, mk(0, 128, 128, 0), "slow_mult");

        // Unknown mode is not accepted.
        issue(8'h00, 8'd0, 8'd255, 8'd0, 8'd1, 8'd2, 8'd3, 1'b0, mk(0, 0, 0, 0));
        chk("bad_mode_busy", int'(busy), 0);

        // Start while busy is dropped.
        base = outputs_seen + 1;
        issue(8'hA4, 8'd43, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, mk(253, 255, 0, 0));
        chk("busy_after_start", int'(busy), 1);
        repeat (2) @(negedge clk);
        issue(8'h21, 8'd0, 8'd0, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0, mk(0, 0, 0, 0));
        wait_out(base, "busy_ignore");

        // Reset while scaling green (third load request).
        base = ld_rises;
        issue(8'hA4, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, mk(0, 0, 0, 0));
        n = 0;
        while (ld_rises < base + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_mul_g", int'(ld_rises >= base + 3), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_mult_ld", int'(mif.mult_ld), 0);
        chk("midrst_red_out", int'(red_out), 0);
        chk("midrst_green_out", int'(green_out), 0);
        chk("midrst_out_valid", int'(out_valid), 0);

        // Engine works again after reset.
        lat = 0;
        run(8'hA4, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, mk(255, 0, 0, 0), "post_reset");

        repeat (20) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("outputs_count", outputs_seen, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgbw_hue_engine.md
Name: rgbw_hue_engine

Overview:
Parametrised next-generation colour engine. It converts a hue index, tint (white) and intensity into RGBW channel values. Hue is computed directly with sector/fraction arithmetic, so latency is bounded and independent of hue. It adds an RGB-to-RGBW white-extraction mode, a start/busy/out_valid handshake and exact full-scale intensity scaling. It sits between the command decoder and the PWM channels, and shares the team's external sequential multiplier through the ld/ok handshake.

Parameters:
DW, 8, width of every colour, hue, intensity and multiplier-operand field
MODE_BYPASS, 8'h21, mode code: copy inputs straight to the outputs
MODE_WHEEL, 8'hA4, mode code: hue wheel plus tint plus intensity
MODE_EXTRACT, 8'hB5, mode code: derive white as min(R,G,B), then apply intensity

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  request pulse; sampled only when busy=0
mode  in  8  operating mode; sampled with start
hue  in  DW  hue index; 0 = red, wraps at 2^DW
lint  in  DW  intensity; all-ones = unity gain
white_in, red_in, green_in, blue_in  in  DW each  tint / direct channel inputs
mult_a, mult_b  out  DW each  multiplier operands
mult_ld  out  1  multiplier load request
mult_ok  in  1  multiplier result valid
mult_res  in  2*DW  multiplier product
busy  out  1  high from the accepted start until out_valid
out_valid  out  1  one-cycle pulse when new outputs are present
red_out, green_out, blue_out, white_out  out  DW each  registered results

Behaviour:
- Reset (reset=0 at a clk edge), from any state, including mid-multiply:
  - state goes to IDLE.
  - All outputs, mult_a, mult_b, mult_ld, busy and out_valid go to 0.
  - Internal buffers are cleared.
- State machine: IDLE, HUE, TINT, MUL_W, MUL_R, MUL_G, MUL_B, OUT.
- IDLE:
  - On start=1, latch mode, hue, lint and all four channel inputs.
  - MODE_BYPASS: load the outputs from the latched inputs. out_valid pulses on the next cycle. Return to IDLE. No mult_ld.
  - MODE_WHEEL: go to HUE.
  - MODE_EXTRACT: go to TINT.
  - Any other mode: stay in IDLE; busy stays 0; no out_valid.
- HUE:
  - p = hue*6, width DW+3. sec = p>>DW (always 0..5). f = p[DW-1:0]. M = all-ones. d = M-f.
  - sec 0: R=M, G=f, B=0.
  - sec 1: R=d, G=M, B=0.
  - sec 2: R=0, G=M, B=f.
  - sec 3: R=0, G=d, B=M.
  - sec 4: R=f, G=0, B=M.
  - sec 5: R=M, G=0, B=d.
- TINT:
  - Wheel mode: each of R, G, B becomes min(x + white_in, M), saturating. W = white_in.
  - Extract mode: W = min(red_in, green_in, blue_in). Then R = red_in - W, G = green_in - W, B = blue_in - W. No underflow is possible.
- MUL_x (W, R, G, B, in that order):
  - Drive mult_a = lint and mult_b = x.
  - Raise mult_ld only when mult_ok=0 and mult_ld=0. Hold mult_ld until mult_ok=1.
  - On mult_ok=1, capture s = (mult_res + x)[2DW-1:DW], i.e. x*(lint+1)>>DW, then clear mult_ld and advance.
  - No timeout.
- OUT: register all four scaled values, pulse out_valid for one cycle, clear busy, return to IDLE.
- Latency:
  - Wheel: 3 cycles plus 4 multiplier round-trips plus 1.
  - Extract: 2 cycles plus 4 multiplier round-trips plus 1.
- Handshake and holding rules:
  - start while busy=1 is ignored; it is not queued.
  - Outputs hold their values between out_valid pulses.
  - Input changes after the accepted start have no effect on the result in flight.
- Boundaries:
  - lint=M gives exact pass-through (255*256>>8 = 255).
  - lint=0 gives 0 for any x < 2^DW.
  - hue = 2^DW-1 gives sec 5 with d small, so the result is near red and the wheel wraps smoothly.

Decomposition:
- Package rgbw_pkg holds:
  - the mode code constants;
  - the state encoding (3-bit localparams/enum);
  - a saturating-add function and a min3 function.
- One combinational sub-module, hue_sector_map (parameter DW): hue in, R/G/B out.
- The FSM, the multiplier sequencer and the output registers stay in rgbw_hue_engine.

Test Plan:
1. Bypass, DW=8: mode=21, in W/R/G/B = 40/10/20/30, start -> outputs 10/20/30/40, out_valid high for 1 cycle, mult_ld never asserted.
2. Wheel: hue=0, white=0, lint=255 -> R/G/B/W = 255/0/0/0. Repeat with hue=43 -> R=253, G=255, B=0.
3. Wheel: hue=128, lint=128, white=0 -> sec 3, f=0; R/G/B/W = 0/128/128/0 (255*129>>8 = 128).
4. Tint: hue=0, white=100, lint=255 -> R/G/B/W = 255/100/100/100; R saturates, no wrap.
5. Extract: mode=B5, R/G/B = 200/150/50, lint=255 -> R/G/B/W = 150/100/0/50.
6. Handshake robustness:
   - Model mult_ok with 5-cycle latency: result is unchanged.
   - Second start while busy: ignored.
   - reset=0 during MUL_G: all outputs 0, busy 0, mult_ld 0 the next cycle.
